// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_sched_pkg
// Purpose  : Shared types and width helpers for the AES block scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package aes_sched_pkg;

  // Scheduler sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int BLOCK_W_DEF = 128;

  // Width of a channel index; never narrower than one bit
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n
  function automatic int cnt_w(input int n);
    return (n >= 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_block_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the first requester
//            found searching upward from i_ptr+1 (wrapping), one-hot.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import aes_sched_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]       i_req,
  input  logic [ch_w(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]       o_grant,
  output logic                    o_any_grant
);

  int   w_tgt;
  logic w_found;

  // Walk priority slots from ptr+1; constant indices keep the select logic flat
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_tgt   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_tgt = int'(i_ptr) + 1 + i;
      if (w_tgt >= NUM_CH) w_tgt = w_tgt - NUM_CH;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_found && (w_tgt == k) && i_req[k]) begin
          o_grant[k] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

  assign o_any_grant = w_found;

endmodule
`default_nettype wire

// File: rtl/aes_block_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_sched
// Purpose  : Round-robin scheduler feeding receiver blocks into one shared
//            cipher engine; tags results with the source channel and guards
//            against a hung engine with a sticky watchdog flag.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_sched
  import aes_sched_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int BLOCK_W      = BLOCK_W_DEF,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         i_ch_data_ready,
  input  logic [NUM_CH*BLOCK_W-1:0] i_ch_data,
  output logic [NUM_CH-1:0]         o_ch_data_taken,
  input  logic                      i_eng_busy,
  output logic                      o_eng_start,
  output logic [BLOCK_W-1:0]        o_eng_block_in,
  input  logic                      i_eng_done,
  input  logic [BLOCK_W-1:0]        i_eng_block_out,
  output logic                      o_out_valid,
  output logic [BLOCK_W-1:0]        o_out_block,
  output logic [ch_w(NUM_CH)-1:0]   o_out_ch,
  input  logic                      i_out_ready,
  output logic                      o_timeout_err,
  input  logic                      i_clr_err
);

  localparam int c_ch_w = ch_w(NUM_CH);
  localparam int c_gw   = cnt_w(GUARD_CYCLES);
  localparam int c_wd_w = cnt_w(TIMEOUT);

  state_t              r_state, w_state_nxt;
  logic [c_ch_w-1:0]   r_rr;
  logic [c_gw-1:0]     r_guard [NUM_CH];
  logic [c_wd_w-1:0]   r_wd;
  logic [NUM_CH-1:0]   r_taken;
  logic                r_start;
  logic [BLOCK_W-1:0]  r_eng_block_in;
  logic [BLOCK_W-1:0]  r_out_block;
  logic [c_ch_w-1:0]   r_out_ch;
  logic                r_out_valid;
  logic                r_timeout_err;

  logic [NUM_CH-1:0]   w_elig;
  logic [NUM_CH-1:0]   w_grant;
  logic                w_any;
  logic [c_ch_w-1:0]   w_idx;
  logic [BLOCK_W-1:0]  w_sel_block;
  logic                w_do_grant;
  logic                w_done;
  logic                w_timeout;

  // A channel is eligible only once its post-acknowledge guard has expired
  for (genvar k = 0; k < NUM_CH; k++) begin : g_guard
    assign w_elig[k] = i_ch_data_ready[k] && (r_guard[k] == '0);

    // Load on the acknowledge cycle, then count down independent of state
    always_ff @(posedge clk) begin
      if (rst)                             r_guard[k] <= '0;
      else if (r_state == START && r_taken[k]) r_guard[k] <= c_gw'(GUARD_CYCLES);
      else if (r_guard[k] != '0)           r_guard[k] <= r_guard[k] - 1'b1;
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req       (w_elig),
    .i_ptr       (r_rr),
    .o_grant     (w_grant),
    .o_any_grant (w_any)
  );

  // One-hot grant to index and the selected channel's block
  always_comb begin
    w_idx       = '0;
    w_sel_block = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant[k]) begin
        w_idx       = c_ch_w'(k);
        w_sel_block = i_ch_data[k*BLOCK_W +: BLOCK_W];
      end
    end
  end

  assign w_do_grant = (r_state == IDLE) && !i_eng_busy && w_any;
  assign w_done     = (r_state == WAIT) && i_eng_done;
  assign w_timeout  = (r_state == WAIT) && !i_eng_done && (r_wd == c_wd_w'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state sequencing; done beats a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_do_grant) w_state_nxt = START;
      START:   w_state_nxt = WAIT;
      WAIT: begin
        if (w_done)         w_state_nxt = DRAIN;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      DRAIN:   if (i_out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: grant capture, start/ack pulses, watchdog, result and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr           <= c_ch_w'(NUM_CH - 1);
      r_wd           <= '0;
      r_taken        <= '0;
      r_start        <= 1'b0;
      r_eng_block_in <= '0;
      r_out_block    <= '0;
      r_out_ch       <= '0;
      r_out_valid    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_start <= w_do_grant;
      r_taken <= w_do_grant ? w_grant : '0;
      if (w_do_grant) begin
        r_eng_block_in <= w_sel_block;
        r_out_ch       <= w_idx;
        r_rr           <= w_idx;
      end
      if (r_state == START)     r_wd <= '0;
      else if (r_state == WAIT) r_wd <= r_wd + 1'b1;
      if (w_done) begin
        r_out_block <= i_eng_block_out;
        r_out_valid <= 1'b1;
      end else if (r_state == DRAIN && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_timeout)      r_timeout_err <= 1'b1;
      else if (i_clr_err) r_timeout_err <= 1'b0;
    end
  end

  assign o_ch_data_taken = r_taken;
  assign o_eng_start     = r_start;
  assign o_eng_block_in  = r_eng_block_in;
  assign o_out_valid     = r_out_valid;
  assign o_out_block     = r_out_block;
  assign o_out_ch        = r_out_ch;
  assign o_timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_sched
// Purpose  : Directed self-checking bench for aes_block_sched
//            (NUM_CH=2, GUARD_CYCLES=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_sched;

  localparam int NCH = 2;
  localparam int BW  = 128;

  localparam logic [BW-1:0] BLK_A = 128'h1234567890abcdef1234567890abcdef;
  localparam logic [BW-1:0] BLK_B0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] BLK_B1 = 128'hfeedfacecafebeef0123456789abcdef;
  localparam logic [BW-1:0] BLK_C = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [BW-1:0] BLK_D = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [BW-1:0] BLK_E = 128'h55555555aaaaaaaa55555555aaaaaaaa;
  localparam logic [BW-1:0] BLK_F = 128'h13579bdf2468ace013579bdf2468ace0;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*BW-1:0] ch_data;
  logic [NCH-1:0]    ch_taken;
  logic              eng_busy, eng_start, eng_done;
  logic [BW-1:0]     eng_in, eng_out, out_block;
  logic              out_valid, out_ready, timeout_err, clr_err;
  logic [0:0]        out_ch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_block_sched #(
    .NUM_CH(NCH), .BLOCK_W(BW), .GUARD_CYCLES(4), .TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_ch_data_ready (ch_ready),
    .i_ch_data       (ch_data),
    .o_ch_data_taken (ch_taken),
    .i_eng_busy      (eng_busy),
    .o_eng_start     (eng_start),
    .o_eng_block_in  (eng_in),
    .i_eng_done      (eng_done),
    .i_eng_block_out (eng_out),
    .o_out_valid     (out_valid),
    .o_out_block     (out_block),
    .o_out_ch        (out_ch),
    .i_out_ready     (out_ready),
    .o_timeout_err   (timeout_err),
    .i_clr_err       (clr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (!eng_start && n < 20) begin
      step();
      n++;
    end
    ok = eng_start;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_ready = '0; ch_data = '0; eng_busy = 1'b0; eng_done = 1'b0;
    eng_out = '0; out_ready = 1'b1; clr_err = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ch_taken !== 2'b00 || eng_start !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: taken=%b start=%b required 00/0", ch_taken, eng_start);
    end
    checks++;
    if (eng_in !== '0 || out_block !== '0) begin
      errors++; $display("FAIL reset_blocks: eng_in=%h out_block=%h required 0", eng_in, out_block);
    end
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_out: valid=%b ch=%b err=%b required 0", out_valid, out_ch, timeout_err);
    end
    step();
    checks++;
    if (eng_start !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: start=%b valid=%b required 0", eng_start, out_valid);
    end
  endtask

  task automatic test_single();
    bit bad;
    ch_data[BW-1:0] = BLK_A;
    ch_ready = 2'b01;
    step();
    checks++;
    if (eng_start !== 1'b1 || ch_taken !== 2'b01) begin
      errors++; $display("FAIL single_start: start=%b taken=%b required 1/01", eng_start, ch_taken);
    end
    checks++;
    if (eng_in !== BLK_A) begin
      errors++; $display("FAIL single_eng_in: got %h required %h", eng_in, BLK_A);
    end
    ch_ready = 2'b00;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (eng_start !== 1'b0 || ch_taken !== 2'b00 || out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL single_wait_quiet: start/taken/valid seen high, required low");
    end
    eng_done = 1'b1; eng_out = ~BLK_A;
    step();
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 1'b0 || out_block !== ~BLK_A) begin
      errors++; $display("FAIL single_result: valid=%b ch=%b blk=%h required 1/0/%h", out_valid, out_ch, out_block, ~BLK_A);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_once: valid=%b required 0", out_valid);
    end
    eng_done = 1'b1; eng_out = '1;
    step();
    eng_done = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || eng_start !== 1'b0) begin
      errors++; $display("FAIL stray_done: valid=%b start=%b required 0/0", out_valid, eng_start);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [1:0]    exp_taken;
    logic [BW-1:0] exp_blk;
    do_reset();
    ch_data = {BLK_B1, BLK_B0};
    ch_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_taken = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_blk   = (t % 2 == 0) ? ~BLK_B0 : ~BLK_B1;
      wait_start(ok);
      checks++;
      if (!ok || ch_taken !== exp_taken) begin
        errors++; $display("FAIL rr_grant%0d: start=%b taken=%b required 1/%b", t, eng_start, ch_taken, exp_taken);
      end
      step(); step();
      eng_done = 1'b1; eng_out = exp_blk;
      step();
      eng_done = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_taken[1] || out_block !== exp_blk) begin
        errors++; $display("FAIL rr_result%0d: valid=%b ch=%b blk=%h required 1/%b/%h", t, out_valid, out_ch, out_block, exp_taken[1], exp_blk);
      end
    end
    ch_ready = 2'b00;
    step(); step();
  endtask

  task automatic test_guard();
    bit ok;
    bit bad;
    do_reset();
    ch_data[2*BW-1:BW] = BLK_C;
    ch_ready = 2'b10;
    wait_start(ok);
    checks++;
    if (!ok || ch_taken !== 2'b10) begin
      errors++; $display("FAIL guard_first: start=%b taken=%b required 1/10", eng_start, ch_taken);
    end
    step();
    eng_done = 1'b1; eng_out = ~BLK_C;
    step();
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 1'b1) begin
      errors++; $display("FAIL guard_result: valid=%b ch=%b required 1/1", out_valid, out_ch);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (eng_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL guard_block: start=1 before guard expiry, required 0");
    end
    step();
    checks++;
    if (eng_start !== 1'b1 || ch_taken !== 2'b10) begin
      errors++; $display("FAIL guard_regrant: start=%b taken=%b required 1/10", eng_start, ch_taken);
    end
    ch_ready = 2'b00;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step(); step();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    do_reset();
    ch_data = {BLK_E, BLK_D};
    ch_ready = 2'b01;
    out_ready = 1'b0;
    wait_start(ok);
    ch_ready = 2'b10;
    step();
    eng_done = 1'b1; eng_out = ~BLK_D;
    step();
    eng_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_block !== ~BLK_D || out_ch !== 1'b0 || eng_start !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (!ok || bad) begin
      errors++; $display("FAIL bp_hold: ok=%b bad=%b, required stable valid and no start", ok, bad);
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid_at_ready: valid=%b required 1", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || eng_start !== 1'b0) begin
      errors++; $display("FAIL bp_release: valid=%b start=%b required 0/0", out_valid, eng_start);
    end
    step();
    checks++;
    if (eng_start !== 1'b1 || ch_taken !== 2'b10 || eng_in !== BLK_E) begin
      errors++; $display("FAIL bp_next_grant: start=%b taken=%b in=%h required 1/10/%h", eng_start, ch_taken, eng_in, BLK_E);
    end
    ch_ready = 2'b00;
    step();
    eng_done = 1'b1; eng_out = ~BLK_E;
    step();
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 1'b1 || out_block !== ~BLK_E) begin
      errors++; $display("FAIL bp_second: valid=%b ch=%b blk=%h required 1/1/%h", out_valid, out_ch, out_block, ~BLK_E);
    end
    step(); step();
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    ch_data = {BLK_F, BLK_A};
    ch_ready = 2'b01;
    wait_start(ok);
    ch_ready = 2'b10;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (!ok || timeout_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL to_early: ok=%b err=%b valid=%b required 1/0/0", ok, timeout_err, out_valid);
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL to_flag: err=%b valid=%b required 1/0", timeout_err, out_valid);
    end
    step();
    checks++;
    if (eng_start !== 1'b1 || ch_taken !== 2'b10) begin
      errors++; $display("FAIL to_next_grant: start=%b taken=%b required 1/10", eng_start, ch_taken);
    end
    ch_ready = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) clr_err = 1'b1;
      if (i == 2) begin
        clr_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
          errors++; $display("FAIL to_clear: err=%b required 0", timeout_err);
        end
      end
      if (i == 8) begin
        eng_done = 1'b1; eng_out = ~BLK_F;
      end
    end
    step();
    eng_done = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || out_valid !== 1'b1 || out_block !== ~BLK_F || out_ch !== 1'b1) begin
      errors++; $display("FAIL to_done_wins: err=%b valid=%b blk=%h ch=%b required 0/1/%h/1", timeout_err, out_valid, out_block, out_ch, ~BLK_F);
    end
    ch_ready = 2'b01;
    clr_err = 1'b1;
    wait_start(ok);
    ch_ready = 2'b00;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (!ok || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_set_over_clr: ok=%b err=%b required 1/1", ok, timeout_err);
    end
    step();
    clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_clr_after: err=%b required 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ch_data = {BLK_C, BLK_D};
    ch_ready = 2'b10;
    wait_start(ok);
    ch_ready = 2'b00;
    step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (!ok || ch_taken !== 2'b00 || eng_start !== 1'b0 || eng_in !== '0 || out_valid !== 1'b0 ||
        out_block !== '0 || out_ch !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset_out: ok=%b taken=%b start=%b in=%h valid=%b ch=%b required all 0", ok, ch_taken, eng_start, eng_in, out_valid, out_ch);
    end
    rst = 1'b0;
    eng_done = 1'b1; eng_out = ~BLK_C;
    ch_ready = 2'b11;
    step();
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_drop: valid=%b required 0", out_valid);
    end
    checks++;
    if (eng_start !== 1'b1 || ch_taken !== 2'b01) begin
      errors++; $display("FAIL mid_reset_ch0_first: start=%b taken=%b required 1/01", eng_start, ch_taken);
    end
    ch_ready = 2'b00;
    step();
    eng_done = 1'b1; eng_out = ~BLK_D;
    step();
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 1'b0 || out_block !== ~BLK_D) begin
      errors++; $display("FAIL mid_reset_after: valid=%b ch=%b blk=%h required 1/0/%h", out_valid, out_ch, out_block, ~BLK_D);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_guard();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
